// File: rtl/pulse_seq_pkg.sv
// Shared encodings for the pulse sequence generator: counter width default,
// run-mode encodings and the sequencer state type.
package pulse_seq_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_SHOT = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pulse_window.sv
// One programmable pulse window: hit while start <= cnt < start + width.
// The end point is formed one bit wider than the counter so start + width
// can never wrap around. A zero width gives an empty window.
module pulse_window
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic [CNT_W-1:0] start_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             hit_o
);

  logic [CNT_W:0] stop_x;

  // Window compare against the exclusive, overflow-free end point.
  always_comb begin
    stop_x = {1'b0, start_i} + {1'b0, width_i};
    hit_o  = en_i && (cnt_i >= start_i) && ({1'b0, cnt_i} < stop_x);
  end

endmodule

// File: rtl/pulse_seq_gen.sv
// N-pulse sequence generator. A period counter runs 0..period-1 while in RUN;
// each enabled window that covers the current count drives the OR'd output,
// which is retimed through a flop so it is glitch-free. Configuration is
// captured into pending registers and only copied to the active set at a
// period boundary (wrap to 0) or while idle, so a period never mixes configs.
module pulse_seq_gen
  import pulse_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned N_PULSES   = 4,
  parameter int unsigned DEF_PERIOD = 200000,
  parameter int unsigned DEF_P0_ST  = 0,
  parameter int unsigned DEF_P0_W   = 30,
  parameter int unsigned DEF_P1_ST  = 230,
  parameter int unsigned DEF_P1_W   = 60
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      mode,
  input  logic                      trig,
  input  logic                      cfg_load,
  input  logic [CNT_W-1:0]          cfg_period,
  input  logic [N_PULSES*CNT_W-1:0] cfg_start,
  input  logic [N_PULSES*CNT_W-1:0] cfg_width,
  input  logic [N_PULSES-1:0]       cfg_en,
  output logic                      out,
  output logic                      sync,
  output logic                      busy,
  output logic                      cfg_err
);

  // Sequencer state and period counter
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_cnt;
  logic               wrap;

  // Active configuration (drives the windows)
  logic [CNT_W-1:0]                 act_period_q;
  logic [N_PULSES-1:0][CNT_W-1:0]   act_start_q;
  logic [N_PULSES-1:0][CNT_W-1:0]   act_width_q;
  logic [N_PULSES-1:0]              act_en_q;

  // Pending (shadow) configuration
  logic [CNT_W-1:0]                 pend_period_q;
  logic [N_PULSES-1:0][CNT_W-1:0]   pend_start_q;
  logic [N_PULSES-1:0][CNT_W-1:0]   pend_width_q;
  logic [N_PULSES-1:0]              pend_en_q;
  logic                             pend_vld_q;

  // Power-on window set
  logic [N_PULSES-1:0][CNT_W-1:0]   def_start;
  logic [N_PULSES-1:0][CNT_W-1:0]   def_width;
  logic [N_PULSES-1:0]              def_en;

  // Config handshake
  logic load_ok;
  logic load_bad;
  logic apply;

  // Window hits and output next-state
  logic [N_PULSES-1:0] hit;
  logic                out_d, sync_d, busy_d, cfg_err_d;
  logic                out_q, sync_q, busy_q, cfg_err_q;

  for (genvar g = 0; g < N_PULSES; g++) begin : g_win
    pulse_window #(
      .CNT_W (CNT_W)
    ) u_win (
      .start_i (act_start_q[g]),
      .width_i (act_width_q[g]),
      .en_i    (act_en_q[g]),
      .cnt_i   (cnt_q),
      .hit_o   (hit[g])
    );
  end

  // Reset window set: pulses 0 and 1 enabled with their defaults, rest off.
  always_comb begin
    for (int i = 0; i < N_PULSES; i++) begin
      def_start[i] = '0;
      def_width[i] = '0;
      def_en[i]    = 1'b0;
      if (i == 0) begin
        def_start[i] = CNT_W'(DEF_P0_ST);
        def_width[i] = CNT_W'(DEF_P0_W);
        def_en[i]    = 1'b1;
      end else if (i == 1) begin
        def_start[i] = CNT_W'(DEF_P1_ST);
        def_width[i] = CNT_W'(DEF_P1_W);
        def_en[i]    = 1'b1;
      end
    end
  end

  // Next state / counter: start from IDLE on run or trig, end or wrap at period-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wrap     = 1'b0;
    last_cnt = (cnt_q == (act_period_q - CNT_W'(1)));
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (((mode == MODE_CONT) && run) || ((mode == MODE_SHOT) && trig)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_cnt) begin
          cnt_d = '0;
          if ((mode == MODE_SHOT) || !run) begin
            state_d = ST_IDLE;
          end else begin
            wrap = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Config acceptance and apply point; a period never changes config mid-way.
  always_comb begin
    load_ok  = cfg_load && (cfg_period >= CNT_W'(2));
    load_bad = cfg_load && (cfg_period <  CNT_W'(2));
    apply    = pend_vld_q && ((state_q == ST_IDLE) || wrap);
  end

  // Output next-state: all outputs are one cycle behind the counter.
  always_comb begin
    out_d     = (state_q == ST_RUN) && (|hit);
    sync_d    = (state_q == ST_RUN) && (cnt_q == '0);
    busy_d    = (state_d == ST_RUN);
    cfg_err_d = load_bad;
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Active config: defaults on reset, otherwise copied from pending at apply.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_period_q <= CNT_W'(DEF_PERIOD);
      act_start_q  <= def_start;
      act_width_q  <= def_width;
      act_en_q     <= def_en;
    end else if (apply) begin
      act_period_q <= pend_period_q;
      act_start_q  <= pend_start_q;
      act_width_q  <= pend_width_q;
      act_en_q     <= pend_en_q;
    end
  end

  // Pending flag: a new load wins over a same-cycle apply of the older value.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
    end else if (load_ok) begin
      pend_vld_q <= 1'b1;
    end else if (apply) begin
      pend_vld_q <= 1'b0;
    end
  end

  // Pending data: only meaningful while the pending flag is set.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      pend_period_q <= cfg_period;
      pend_start_q  <= cfg_start;
      pend_width_q  <= cfg_width;
      pend_en_q     <= cfg_en;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= 1'b0;
      sync_q    <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      sync_q    <= sync_d;
      busy_q    <= busy_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out     = out_q;
  assign sync    = sync_q;
  assign busy    = busy_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Bench for pulse_seq_gen: reset state, default windows, a table of
// single-shot window cases, hand sequences for mid-period reconfiguration,
// rejected loads and reset during a pulse, then random stimulus against a
// behavioural model. The default period is shortened to keep runs short.
module tb_pulse_seq_gen;

  localparam int CW = 32;
  localparam int NP = 4;
  localparam int DP = 500;

  logic              clk = 1'b0;
  logic              rst, run, mode, trig, cfg_load;
  logic [CW-1:0]     cfg_period;
  logic [NP*CW-1:0]  cfg_start, cfg_width;
  logic [NP-1:0]     cfg_en;
  logic              out, sync, busy, cfg_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pulse_seq_gen #(
    .CNT_W      (CW),
    .N_PULSES   (NP),
    .DEF_PERIOD (DP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .mode       (mode),
    .trig       (trig),
    .cfg_load   (cfg_load),
    .cfg_period (cfg_period),
    .cfg_start  (cfg_start),
    .cfg_width  (cfg_width),
    .cfg_en     (cfg_en),
    .out        (out),
    .sync       (sync),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  typedef struct {
    int                    p;
    logic [NP-1:0][CW-1:0] st;
    logic [NP-1:0][CW-1:0] w;
    logic [NP-1:0]         en;
    int                    exp_cnt;
    int                    exp_first;
    int                    exp_last;
    int                    trig_at;
  } vec_t;

  vec_t vt[13];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int p, input logic [NP-1:0][CW-1:0] st,
                          input logic [NP-1:0][CW-1:0] w, input logic [NP-1:0] en);
    cfg_period = CW'(p);
    cfg_start  = st;
    cfg_width  = w;
    cfg_en     = en;
    cfg_load   = 1'b1;
    tick();
    cfg_load   = 1'b0;
  endtask

  task automatic wait_sync(input string tag, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (sync) begin
        found = 1'b1;
        break;
      end
    end
    chk_bit({tag, "_sync_seen"}, found, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      tick();
    end
    chk_bit({tag, "_idle"}, busy, 1'b0);
  endtask

  // Default windows 0..29 and 230..289 every DP cycles in continuous mode.
  task automatic check_defaults(input string tag);
    bit f;
    wait_sync(tag, 10, f);
    if (f) begin
      for (int k = 0; k < 2 * DP; k++) begin
        int j;
        if (k > 0) tick();
        j = k % DP;
        chk_bit($sformatf("%s_out k=%0d", tag, k), out, (j < 30) || (j >= 230 && j < 290));
        chk_bit($sformatf("%s_sync k=%0d", tag, k), sync, j == 0);
      end
    end
  endtask

  function automatic vec_t mk(input int p, input logic [CW-1:0] s0, input logic [CW-1:0] w0,
                              input logic [CW-1:0] s1, input logic [CW-1:0] w1,
                              input logic [CW-1:0] s2, input logic [CW-1:0] w2,
                              input logic [NP-1:0] en, input int c, input int f,
                              input int l, input int ta);
    vec_t v;
    v.p = p;
    v.st = {32'd0, s2, s1, s0};
    v.w  = {32'd0, w2, w1, w0};
    v.en = en;
    v.exp_cnt = c;
    v.exp_first = f;
    v.exp_last = l;
    v.trig_at = ta;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  longint m_act_p, m_pen_p, m_pos;
  longint m_act_st[NP], m_act_w[NP], m_pen_st[NP], m_pen_w[NP];
  bit     m_act_en[NP], m_pen_en[NP];
  bit     m_pvld, m_running;
  bit     m_out, m_sync, m_busy, m_err;

  function automatic bit covered(input longint pos);
    for (int i = 0; i < NP; i++) begin
      if (m_act_en[i] && pos >= m_act_st[i] && pos < m_act_st[i] + m_act_w[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step();
    bit can_apply;
    if (rst) begin
      {m_out, m_sync, m_busy, m_err} = 4'b0;
      m_running = 1'b0;
      m_pos = 0;
      m_pvld = 1'b0;
      m_act_p = DP;
      for (int i = 0; i < NP; i++) begin
        m_act_st[i] = 0; m_act_w[i] = 0; m_act_en[i] = 1'b0;
      end
      m_act_st[0] = 0;   m_act_w[0] = 30; m_act_en[0] = 1'b1;
      m_act_st[1] = 230; m_act_w[1] = 60; m_act_en[1] = 1'b1;
      return;
    end
    m_out  = m_running && covered(m_pos);
    m_sync = m_running && (m_pos == 0);
    m_err  = cfg_load && (cfg_period < 2);
    can_apply = !m_running;
    if (!m_running) begin
      if ((mode == 1'b0 && run) || (mode == 1'b1 && trig)) begin
        m_running = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == m_act_p - 1) begin
      m_pos = 0;
      if (mode == 1'b1 || !run) m_running = 1'b0;
      else can_apply = 1'b1;
    end else begin
      m_pos++;
    end
    if (can_apply && m_pvld) begin
      m_act_p = m_pen_p; m_act_st = m_pen_st; m_act_w = m_pen_w; m_act_en = m_pen_en;
      m_pvld = 1'b0;
    end
    if (cfg_load && cfg_period >= 2) begin
      m_pen_p = cfg_period;
      for (int i = 0; i < NP; i++) begin
        m_pen_st[i] = cfg_start[i*CW +: CW];
        m_pen_w[i]  = cfg_width[i*CW +: CW];
        m_pen_en[i] = cfg_en[i];
      end
      m_pvld = 1'b1;
    end
    m_busy = m_running;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit f;
    vt[0]  = mk(100, 90, 20, 0, 0, 0, 0, 4'b0001, 10, 90, 99, -1);
    vt[1]  = mk(20, 0, 5, 3, 4, 0, 0, 4'b0011, 7, 0, 6, -1);
    vt[2]  = mk(20, 5, 0, 0, 0, 0, 0, 4'b0001, 0, -1, -1, -1);
    vt[3]  = mk(20, 25, 3, 0, 0, 0, 0, 4'b0001, 0, -1, -1, -1);
    vt[4]  = mk(20, 2, 3, 10, 2, 0, 0, 4'b0010, 2, 10, 11, -1);
    vt[5]  = mk(2, 1, 1, 0, 0, 0, 0, 4'b0001, 1, 1, 1, -1);
    vt[6]  = mk(16, 0, 16, 0, 0, 0, 0, 4'b0001, 16, 0, 15, -1);
    vt[7]  = mk(16, 4, 3, 7, 2, 0, 0, 4'b0011, 5, 4, 8, -1);
    vt[8]  = mk(30, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0, 4'b0001, 0, -1, -1, -1);
    vt[9]  = mk(10, 3, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'b0001, 7, 3, 9, -1);
    vt[10] = mk(10, 0, 0, 0, 0, 5, 2, 4'b0100, 2, 5, 6, -1);
    vt[11] = mk(20, 0, 3, 0, 0, 0, 0, 4'b0001, 3, 0, 2, 7);
    vt[12] = mk(20, 18, 10, 0, 0, 0, 0, 4'b0001, 2, 18, 19, -1);

    rst = 1'b1; run = 1'b0; mode = 1'b0; trig = 1'b0; cfg_load = 1'b0;
    cfg_period = '0; cfg_start = '0; cfg_width = '0; cfg_en = '0;
    repeat (3) tick();
    chk_bit("reset_out", out, 1'b0);
    chk_bit("reset_sync", sync, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_cfg_err", cfg_err, 1'b0);
    rst = 1'b0;
    tick();
    chk_bit("idle_busy", busy, 1'b0);

    // Reset defaults in continuous mode
    mode = 1'b0; run = 1'b1;
    check_defaults("dflt");
    run = 1'b0;
    mode = 1'b1;
    wait_idle("dflt_end", 2 * DP);

    // Single-shot window table
    for (int n = 0; n < 13; n++) begin
      int ocnt, scnt, bcnt, sidx, first, last;
      mode = 1'b1; run = 1'b0; trig = 1'b0;
      wait_idle($sformatf("v%0d", n), 200);
      load_cfg(vt[n].p, vt[n].st, vt[n].w, vt[n].en);
      tick(); tick();
      ocnt = 0; scnt = 0; bcnt = 0; sidx = -1; first = -1; last = -1;
      trig = 1'b1;
      for (int i = 0; i < 3 * vt[n].p + 10; i++) begin
        tick();
        if (sync) begin
          scnt++;
          if (sidx < 0) sidx = i;
        end
        if (busy) bcnt++;
        if (out) begin
          int rel;
          rel = (sidx >= 0) ? i - sidx : -1000;
          if (ocnt == 0) first = rel;
          last = rel;
          ocnt++;
        end
        trig = (i == vt[n].trig_at);
      end
      chk_int($sformatf("v%0d_sync_count", n), scnt, 1);
      chk_int($sformatf("v%0d_busy_cycles", n), bcnt, vt[n].p);
      chk_int($sformatf("v%0d_out_cycles", n), ocnt, vt[n].exp_cnt);
      chk_int($sformatf("v%0d_out_first", n), first, vt[n].exp_first);
      chk_int($sformatf("v%0d_out_last", n), last, vt[n].exp_last);
    end

    // Mid-period reload to P=50 and a rejected load with period 1
    load_cfg(100, {32'd0, 32'd0, 32'd0, 32'd90}, {32'd0, 32'd0, 32'd0, 32'd20}, 4'b0001);
    tick(); tick();
    mode = 1'b0; run = 1'b1;
    wait_sync("reload", 10, f);
    if (f) begin
      for (int k = 0; k < 250; k++) begin
        bit eo, es;
        if (k > 0) tick();
        if (k < 100) begin
          eo = (k >= 90);
          es = (k == 0);
        end else begin
          eo = ((k - 100) % 50 >= 10) && ((k - 100) % 50 < 15);
          es = ((k - 100) % 50 == 0);
        end
        chk_bit($sformatf("reload_out k=%0d", k), out, eo);
        chk_bit($sformatf("reload_sync k=%0d", k), sync, es);
        chk_bit($sformatf("reload_busy k=%0d", k), busy, 1'b1);
        chk_bit($sformatf("reload_cfg_err k=%0d", k), cfg_err, k == 121);
        cfg_load = 1'b0;
        if (k == 40) begin
          cfg_period = 32'd50;
          cfg_start  = {32'd0, 32'd0, 32'd0, 32'd10};
          cfg_width  = {32'd0, 32'd0, 32'd0, 32'd5};
          cfg_en     = 4'b0001;
          cfg_load   = 1'b1;
        end else if (k == 120) begin
          cfg_period = 32'd1;
          cfg_start  = '0;
          cfg_width  = {NP{32'd3}};
          cfg_en     = 4'b1111;
          cfg_load   = 1'b1;
        end
      end
    end
    cfg_load = 1'b0;

    // Reset during a pulse with a fresh config pending
    for (int i = 0; i < 100; i++) begin
      if (out) break;
      tick();
    end
    chk_bit("rst_pre_out", out, 1'b1);
    cfg_period = 32'd7;
    cfg_start  = {32'd0, 32'd0, 32'd0, 32'd1};
    cfg_width  = {32'd0, 32'd0, 32'd0, 32'd2};
    cfg_en     = 4'b0001;
    cfg_load   = 1'b1;
    tick();
    cfg_load = 1'b0;
    rst = 1'b1;
    tick();
    chk_bit("rst_out", out, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_sync", sync, 1'b0);
    chk_bit("rst_cfg_err", cfg_err, 1'b0);
    rst = 1'b0;
    check_defaults("post_rst");

    // Random stimulus against the model
    for (int c = 0; c < 6000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      if ($urandom_range(0, 39) == 0) run = ~run;
      trig = ($urandom_range(0, 9) == 0);
      cfg_load = ($urandom_range(0, 24) == 0);
      if (cfg_load) begin
        cfg_period = $urandom_range(0, 14);
        for (int i = 0; i < NP; i++) begin
          cfg_start[i*CW +: CW] = $urandom_range(0, 15);
          cfg_width[i*CW +: CW] = $urandom_range(0, 8);
        end
        cfg_en = 4'($urandom);
      end
      @(posedge clk);
      model_step();
      #1;
      chk_bit($sformatf("rnd_out c=%0d", c), out, m_out);
      chk_bit($sformatf("rnd_sync c=%0d", c), sync, m_sync);
      chk_bit($sformatf("rnd_busy c=%0d", c), busy, m_busy);
      chk_bit($sformatf("rnd_cfg_err c=%0d", c), cfg_err, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
